mux_pipe_n: RTL
===============

// Module: mux_pipe_n
// PURPOSE
//  Parametrised N-channel, WIDTH-bit selector with a registered output stage and valid/ready handshake.
//  Generalises the 1-bit 2:1 gate mux used in the CORDIC datapath.
//  Routes one of NUM_IN operand streams into the CORDIC iteration pipeline under a per-cycle select.
//  Reports which channel each output beat came from, and flags out-of-range selects.
// PARAMETERS
//  WIDTH   16  data bits per channel
//  NUM_IN  4   number of input channels, >=2
//  SEL_W   2   select width; 2**SEL_W >= NUM_IN is required
// PORTS
//  clk        in   1             rising-edge clock
//  rst_n      in   1             asynchronous active-low reset
//  in_data    in   NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   NUM_IN        per-channel valid
//  in_ready   out  NUM_IN        per-channel ready; at most one bit high
//  sel        in   SEL_W         channel select, sampled every cycle
//  out_data   out  WIDTH         registered selected data
//  out_idx    out  SEL_W         channel index of the beat in out_data
//  out_valid  out  1             output beat valid
//  out_ready  in   1             downstream accept
//  sel_err    out  1             registered 1-cycle pulse: sel >= NUM_IN on the previous cycle
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_data=0, out_idx=0, out_valid=0, sel_err=0, internal buffers empty.
//    in_ready=0 while rst_n=0.
//  - Accept condition: space = !out_valid | out_ready.
//    in_ready[i] = (i==sel) & (sel<NUM_IN) & space.
//    Transfer when in_valid[sel] & in_ready[sel].
//  - Latency: 1 clk from input transfer to out_valid=1. Throughput: 1 beat/clk when out_ready is held high.
//  - Output register:
//    - On transfer: out_data<=in_data[sel], out_idx<=sel, out_valid<=1.
//    - Else if out_ready: out_valid<=0, and out_data/out_idx hold their last values.
//  - Back-pressure: while out_valid & !out_ready, out_data and out_idx are stable and no input is accepted.
//  - Simultaneous pop and push (out_valid & out_ready & transfer): the new beat replaces the old one,
//    out_valid stays 1, and no bubble is inserted.
//  - sel may change every cycle; only the sel value at the transfer edge matters.
//    Unselected channels' valid is ignored; their in_ready is 0.
//  - Out-of-range sel (>= NUM_IN):
//    - no transfer, all in_ready=0;
//    - sel_err=1 on the following cycle, for one cycle per offending cycle;
//    - the output stage keeps draining normally.
//  - Reset asserted mid-beat: the pending beat is discarded with no partial output; after release the
//    block is empty.
// CONFIGURATION
//  MUX_SKID_EN defined:
//    - adds a 1-entry skid register so in_ready is a pure register function,
//      with no combinational path from out_ready to in_ready;
//    - in_ready[i] = (i==sel) & (sel<NUM_IN) & !skid_full;
//    - a beat accepted while the output is stalled goes to skid; skid drains to the output when
//      out_ready=1;
//    - ordering is preserved, capacity is 2 beats, latency 1 clk when not stalled, throughput 1/clk.
//  MUX_SKID_EN undefined: single output register, combinational ready as described above,
//    capacity 1 beat.
// TESTING
//  1. Reset: rst_n=0 with all inputs valid -> out_valid=0, out_data=0, in_ready=0;
//     release, sel=2 -> first beat out 1 clk later with out_idx=2.
//  2. Streaming: sel cycles 0,1,2,3, data 0x1111,0x2222,0x3333,0x4444, out_ready=1 ->
//     the same sequence on out_data, one per clk, out_idx 0..3.
//  3. Stall: out_ready=0 for 5 clk with out_data=0xBEEF ->
//     out_data stable, in_ready=0 (no skid) / one extra beat accepted (skid);
//     both beats then delivered in order.
//  4. Bad select: NUM_IN=3, sel=3 for 2 clk with in_valid=3'b111 ->
//     no transfer, sel_err high for 2 clk, out_valid drops after the drain.
//  5. Mid-beat reset: rst_n low while out_valid=1 & out_ready=0 ->
//     out_valid=0 immediately (async), no stale beat after release.
//  6. Random: random valid/ready/sel for 10k clk vs a reference queue model ->
//     zero mismatches, no loss, no duplication.

Source files
------------

// File: rtl/mux_pipe_n.sv
// -----------------------------------------------------------------------------
// mux_pipe_n
//
// Purpose:
//   Parametrised NUM_IN-channel, WIDTH-bit selector feeding the CORDIC
//   iteration pipeline. One operand stream is chosen per cycle by `sel`,
//   captured into a registered output stage with a valid/ready handshake, and
//   tagged with the index of the channel it came from. Out-of-range selects
//   are rejected and reported one cycle later on `sel_err`.
//
// Configuration:
//   MUX_SKID_EN  (undefined by default)
//     undefined : single output register, capacity 1 beat. in_ready depends
//                 combinationally on out_ready (space = !out_valid | out_ready).
//     defined   : adds a 1-entry skid register, capacity 2 beats. in_ready is
//                 a function of registered state and sel only, so there is no
//                 combinational path from out_ready to in_ready.
//
// Parameters:
//   WIDTH   data bits per channel
//   NUM_IN  number of input channels (>= 2)
//   SEL_W   select width, 2**SEL_W >= NUM_IN
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    channel i at bits [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, at most one bit high, 0 while in reset
//   sel        channel select, sampled every cycle
//   out_data   registered selected data
//   out_idx    channel index of the beat in out_data
//   out_valid  output beat valid
//   out_ready  downstream accept
//   sel_err    registered 1-cycle pulse: sel >= NUM_IN on the previous cycle
// -----------------------------------------------------------------------------
module mux_pipe_n #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    // One extra bit so the range check also works when NUM_IN == 2**SEL_W.
    localparam logic [SEL_W:0] NUM_IN_W = (SEL_W + 1)'(NUM_IN);

    logic                 sel_ok_s;
    logic [NUM_IN-1:0]    onehot_s;
    logic [WIDTH-1:0]     sel_data_s;
    logic                 sel_valid_s;
    logic                 space_s;
    logic                 transfer_s;

    logic [WIDTH-1:0]     out_data_r;
    logic [SEL_W-1:0]     out_idx_r;
    logic                 out_valid_r;
    logic                 sel_err_r;

    // Select decode: range check plus a one-hot channel vector (all zero when out of range).
    always_comb begin
        sel_ok_s = ({1'b0, sel} < NUM_IN_W);
        onehot_s = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            onehot_s[i] = sel_ok_s & (sel == SEL_W'(i));
        end
    end

    // AND-OR data/valid mux driven by the one-hot select; no out-of-range slice is ever formed.
    always_comb begin
        sel_data_s  = '0;
        sel_valid_s = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            sel_data_s  = sel_data_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{onehot_s[i]}});
            sel_valid_s = sel_valid_s | (in_valid[i] & onehot_s[i]);
        end
    end

    // Ready fan-out: only the selected channel sees ready, and nothing is ready during reset.
    always_comb begin
        in_ready = onehot_s & {NUM_IN{space_s & rst_n}};
    end

    // A beat moves when the selected channel is valid and there is room for it.
    always_comb begin
        transfer_s = sel_valid_s & space_s;
    end

    // Out-of-range select flag, one registered pulse per offending cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_r <= 1'b0;
        end else begin
            sel_err_r <= ~sel_ok_s;
        end
    end

`ifdef MUX_SKID_EN

    logic [WIDTH-1:0]     skid_data_r;
    logic [SEL_W-1:0]     skid_idx_r;
    logic                 skid_full_r;
    logic                 drain_s;

    // Input side only looks at the skid flag, so out_ready never reaches in_ready.
    always_comb begin
        space_s = ~skid_full_r;
        drain_s = ~out_valid_r | out_ready;
    end

    // Output stage: refill from skid first to preserve order, otherwise from the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= '0;
            out_idx_r   <= '0;
            out_valid_r <= 1'b0;
        end else if (drain_s) begin
            if (skid_full_r) begin
                out_data_r  <= skid_data_r;
                out_idx_r   <= skid_idx_r;
                out_valid_r <= 1'b1;
            end else if (transfer_s) begin
                out_data_r  <= sel_data_s;
                out_idx_r   <= sel;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Skid register: catches the one beat accepted while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data_r <= '0;
            skid_idx_r  <= '0;
            skid_full_r <= 1'b0;
        end else if (drain_s) begin
            skid_full_r <= 1'b0;
        end else if (transfer_s) begin
            skid_data_r <= sel_data_s;
            skid_idx_r  <= sel;
            skid_full_r <= 1'b1;
        end else begin
            skid_full_r <= skid_full_r;
        end
    end

`else

    // Room exists when the output is empty or is being popped this cycle.
    always_comb begin
        space_s = ~out_valid_r | out_ready;
    end

    // Single output register: a push replaces a popped beat with no bubble; data holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= '0;
            out_idx_r   <= '0;
            out_valid_r <= 1'b0;
        end else if (transfer_s) begin
            out_data_r  <= sel_data_s;
            out_idx_r   <= sel;
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

`endif

    assign out_data  = out_data_r;
    assign out_idx   = out_idx_r;
    assign out_valid = out_valid_r;
    assign sel_err   = sel_err_r;

endmodule
